coeff_loader: RTL and testbench

- Coefficient programming and readback engine for the filter core's fractional decimator.
- Accepts coefficients one word per beat over a valid/ready stream and assembles them into a shadow bank of N_TAP words. On the final word it drives the decimator's parallel coefficient bus with a one-cycle write-enable pulse.
- On request it snapshots the decimator's parallel coefficient-readback bus and streams it back out serially.
- Sits between the configuration interface and the core's frac_dec_coeff_* ports.

---
 rtl/coeff_loader.sv | 120 ++++++++++++
 tb/tb_coeff_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_loader.sv
// rtl/coeff_loader.sv - coefficient load/commit and readback engine for the fractional decimator
module coeff_loader #(
  parameter  int COEFF_WIDTH = 20,
  parameter  int N_TAP       = 72,
  localparam int IDX_W       = $clog2(N_TAP)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 load_start,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [COEFF_WIDTH-1:0]               s_data,
  input  logic                                 s_last,
  input  logic                                 rb_start,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [COEFF_WIDTH-1:0]               m_data,
  output logic                                 m_last,
  output logic                                 coeff_wr_en,
  output logic [N_TAP-1:0][COEFF_WIDTH-1:0]    coeff_data_out,
  input  logic [N_TAP-1:0][COEFF_WIDTH-1:0]    coeff_data_in,
  output logic                                 busy,
  output logic                                 load_err
);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, RDBK} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TAP - 1);

  state_t                            state, state_nxt;
  logic [IDX_W-1:0]                  idx;
  logic [N_TAP-1:0][COEFF_WIDTH-1:0] shadow;
  logic                              at_last, s_beat, m_beat;

  assign at_last        = (idx == LAST_IDX);
  // A restart in LOAD stalls the stream for one cycle so no word lands at a stale index.
  assign s_ready        = (state == LOAD) && !load_start;
  assign s_beat         = s_valid && s_ready;
  assign m_valid        = (state == RDBK);
  assign m_beat         = m_valid && m_ready;
  assign m_data         = m_valid ? shadow[idx] : '0;
  assign m_last         = m_valid && at_last;
  assign coeff_wr_en    = (state == COMMIT);
  assign busy           = (state != IDLE);
  assign coeff_data_out = shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_nxt = LOAD;
        end else if (rb_start) begin
          state_nxt = RDBK;
        end
      end
      LOAD: begin
        if (s_beat && (at_last || s_last)) begin
          state_nxt = (at_last && s_last) ? COMMIT : IDLE;
        end
      end
      COMMIT: state_nxt = IDLE;
      RDBK: begin
        if (m_beat && at_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      shadow   <= '0;
      load_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            idx      <= '0;
            load_err <= 1'b0;
          end else if (rb_start) begin
            idx    <= '0;
            shadow <= coeff_data_in;
          end
        end
        LOAD: begin
          if (load_start) begin
            idx <= '0;
          end else if (s_beat) begin
            shadow[idx] <= s_data;
            // Terminating beat: either a clean end of bank or a length mismatch.
            if (at_last || s_last) begin
              idx      <= '0;
              load_err <= !(at_last && s_last);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        RDBK: begin
          if (m_beat) begin
            idx <= at_last ? '0 : idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_loader.sv
// tb/tb_coeff_loader.sv - randomized self-checking bench for coeff_loader
module tb_coeff_loader;

  localparam int CW = 20;
  localparam int NT = 72;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 load_start, s_valid, s_ready, s_last;
  logic [CW-1:0]        s_data;
  logic                 rb_start, m_valid, m_ready, m_last;
  logic [CW-1:0]        m_data;
  logic                 coeff_wr_en, busy, load_err, tie;
  logic [NT-1:0][CW-1:0] coeff_data_out, coeff_data_in, alt_bank, wr_snap;

  int n_vec    = 0;
  int n_err    = 0;
  int wr_count = 0;

  // Expected shadow bank contents and the words of the load in progress.
  logic [CW-1:0] model [NT];
  logic [CW-1:0] words [NT];

  always #5 clk = ~clk;

  assign coeff_data_in = tie ? coeff_data_out : alt_bank;

  coeff_loader #(.COEFF_WIDTH(CW), .N_TAP(NT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_start     (load_start),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .rb_start       (rb_start),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .coeff_wr_en    (coeff_wr_en),
    .coeff_data_out (coeff_data_out),
    .coeff_data_in  (coeff_data_in),
    .busy           (busy),
    .load_err       (load_err)
  );

  always @(negedge clk) begin
    if (coeff_wr_en === 1'b1) begin
      wr_count++;
      wr_snap = coeff_data_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input bit seq);
    for (int i = 0; i < NT; i++) begin
      words[i] = seq ? CW'(i + 1) : CW'($urandom);
    end
  endtask

  task automatic bank_check(input string tag);
    for (int t = 0; t < NT; t++) begin
      check(tag, coeff_data_out[t], model[t]);
    end
  endtask

  task automatic pulse_load_start(input bit junk);
    load_start = 1'b1;
    s_valid    = junk;
    s_data     = CW'($urandom);
    s_last     = junk && ($urandom_range(0, 1) != 0);
    @(negedge clk);
    check("s_ready_on_start", s_ready, 1'b0);
    tick();
    load_start = 1'b0;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    @(negedge clk);
    check("s_ready_load", s_ready, 1'b1);
    check("load_err_clr", load_err, 1'b0);
    check("busy_load", busy, 1'b1);
    tick();
  endtask

  task automatic load(input int n, input int last_at, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          s_valid = 1'b0;
          tick();
        end
      end
      s_valid = 1'b1;
      s_data  = words[i];
      s_last  = (i + 1 == last_at);
      @(negedge clk);
      check("s_ready_beat", s_ready, 1'b1);
      tick();
      model[i] = words[i];
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic commit_check();
    int c0;
    c0 = wr_count;
    @(negedge clk);
    check("wr_en_pulse", coeff_wr_en, 1'b1);
    check("busy_commit", busy, 1'b1);
    check("load_err_ok", load_err, 1'b0);
    check("bank_first", coeff_data_out[0], model[0]);
    check("bank_last", coeff_data_out[NT-1], model[NT-1]);
    tick();
    @(negedge clk);
    check("wr_en_drop", coeff_wr_en, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("wr_pulses", wr_count, c0 + 1);
    for (int t = 0; t < NT; t++) begin
      check("commit_snap", wr_snap[t], model[t]);
    end
    tick();
  endtask

  task automatic bad_load_check();
    @(negedge clk);
    check("load_err_set", load_err, 1'b1);
    check("busy_err", busy, 1'b0);
    check("wr_en_err", coeff_wr_en, 1'b0);
    bank_check("partial_bank");
    tick();
  endtask

  task automatic readback(input bit toggle, input bit noise);
    int k, cyc, c0;
    k   = 0;
    cyc = 0;
    c0  = wr_count;
    if (!tie) begin
      for (int t = 0; t < NT; t++) model[t] = alt_bank[t];
    end
    rb_start = 1'b1;
    @(negedge clk);
    check("m_valid_idle", m_valid, 1'b0);
    tick();
    rb_start = 1'b0;
    while (k < NT && cyc < 2000) begin
      m_ready    = toggle ? ~cyc[0] : 1'($urandom_range(0, 1));
      load_start = noise && ($urandom_range(0, 3) == 0);
      rb_start   = noise && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      check("m_valid_rb", m_valid, 1'b1);
      check("m_data_rb", m_data, model[k]);
      check("m_last_rb", m_last, k == NT - 1);
      check("s_ready_rb", s_ready, 1'b0);
      tick();
      if (m_ready) k++;
      cyc++;
    end
    m_ready    = 1'b0;
    load_start = 1'b0;
    rb_start   = 1'b0;
    check("rb_beats", k, NT);
    @(negedge clk);
    check("m_valid_end", m_valid, 1'b0);
    check("busy_rb_end", busy, 1'b0);
    check("wr_en_none_rb", wr_count, c0);
    bank_check("rb_bank");
    tick();
  endtask

  initial begin
    int c0;
    rst_n      = 1'b0;
    load_start = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    rb_start   = 1'b0;
    m_ready    = 1'b0;
    tie        = 1'b1;
    alt_bank   = '0;
    for (int t = 0; t < NT; t++) model[t] = '0;
    #12;
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, '0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_wr_en", coeff_wr_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_load_err", load_err, 1'b0);
    bank_check("rst_bank");
    tick();
    rst_n = 1'b1;
    tick();

    // Sequential full load, valid held high.
    fill(1'b1);
    pulse_load_start(1'b0);
    load(NT, NT, 1'b0);
    commit_check();

    // Short load, then recovery with a fresh full load.
    c0 = wr_count;
    fill(1'b0);
    pulse_load_start(1'b0);
    load(40, 40, 1'b0);
    bad_load_check();
    check("wr_none_short", wr_count, c0);
    pulse_load_start(1'b1);
    fill(1'b0);
    load(NT, NT, 1'b1);
    commit_check();

    // Full length without s_last.
    c0 = wr_count;
    fill(1'b0);
    pulse_load_start(1'b0);
    load(NT, 0, 1'b1);
    bad_load_check();
    check("wr_none_nolast", wr_count, c0);

    // Reload, then readback through the loopback and from an independent bank.
    fill(1'b0);
    pulse_load_start(1'b0);
    load(NT, NT, 1'b0);
    commit_check();
    tie = 1'b1;
    readback(1'b1, 1'b0);
    tie = 1'b0;
    for (int t = 0; t < NT; t++) alt_bank[t] = CW'($urandom);
    readback(1'b0, 1'b1);
    tie = 1'b1;

    // Restart after 30 words.
    fill(1'b0);
    pulse_load_start(1'b0);
    load(30, 0, 1'b1);
    pulse_load_start(1'b1);
    fill(1'b0);
    load(NT, NT, 1'b0);
    commit_check();
    readback(1'b0, 1'b1);

    // load_start and rb_start together in IDLE.
    load_start = 1'b1;
    rb_start   = 1'b1;
    @(negedge clk);
    check("both_m_valid0", m_valid, 1'b0);
    tick();
    load_start = 1'b0;
    rb_start   = 1'b0;
    @(negedge clk);
    check("both_s_ready", s_ready, 1'b1);
    check("both_m_valid1", m_valid, 1'b0);
    check("both_busy", busy, 1'b1);
    tick();
    fill(1'b0);
    load(NT, NT, 1'b1);
    commit_check();

    // Asynchronous reset at word 50.
    c0 = wr_count;
    fill(1'b0);
    pulse_load_start(1'b0);
    load(50, 0, 1'b0);
    s_valid = 1'b1;
    s_data  = words[50];
    #2;
    rst_n = 1'b0;
    #1;
    for (int t = 0; t < NT; t++) model[t] = '0;
    check("arst_s_ready", s_ready, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_wr_en", coeff_wr_en, 1'b0);
    check("arst_m_valid", m_valid, 1'b0);
    check("arst_m_data", m_data, '0);
    check("arst_load_err", load_err, 1'b0);
    check("arst_bank_zero", |coeff_data_out, 1'b0);
    tick();
    rst_n   = 1'b1;
    s_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_s_ready", s_ready, 1'b0);
    check("post_rst_wr", wr_count, c0);
    bank_check("post_rst_bank");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
